dcpu_bus_arbiter: RTL and testbench

//  Shares one single-port memory/peripheral bus between two masters: M0 is the dcpu core (cs/we/addr/dat/ack),
//  M1 is a DMA or debug master using the same handshake. Round-robin grant, held for a whole transaction.
//  The grant is released on slave ack. A watchdog completes any transaction the slave never acks.

---
 rtl/dcpu_bus_pkg.sv | 19 +
 rtl/dcpu_rr_pick.sv | 22 ++
 rtl/dcpu_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_dcpu_bus_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dcpu_bus_pkg.sv
// Shared types and constants for the dcpu bus arbiter family.
package dcpu_bus_pkg;

    // Arbiter FSM: waiting for a request, or owning the slave for one transaction.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Master indices; also the bit positions inside a one-hot grant.
    localparam int M0 = 0;
    localparam int M1 = 1;

    // One-hot grant encodings.
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/dcpu_rr_pick.sv
// Combinational two-way round-robin picker: a lone requester wins outright,
// a tie goes to whichever master did not own the bus last.
module dcpu_rr_pick
    import dcpu_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Pick the winner from the request pair and the previous owner.
    always_comb begin
        gnt = GNT_NONE;
        case (req)
            2'b01:   gnt = GNT_M0;
            2'b10:   gnt = GNT_M1;
            2'b11:   gnt = (last == 1'(M1)) ? GNT_M0 : GNT_M1;
            default: gnt = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/dcpu_bus_arbiter.sv
// Two-master bus arbiter in front of a single-port slave: round-robin grant
// held for a whole transaction, released on slave ack or watchdog expiry.
module dcpu_bus_arbiter
    import dcpu_bus_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_m0_cs,
    input  logic          i_m0_we,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_dat,
    output logic [DW-1:0] o_m0_dat,
    output logic          o_m0_ack,
    input  logic          i_m1_cs,
    input  logic          i_m1_we,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_dat,
    output logic [DW-1:0] o_m1_dat,
    output logic          o_m1_ack,
    output logic          o_s_cs,
    output logic          o_s_we,
    output logic [AW-1:0] o_s_addr,
    output logic [DW-1:0] o_s_dat,
    input  logic [DW-1:0] i_s_dat,
    input  logic          i_s_ack,
    output logic [1:0]    o_grant,
    output logic          o_timeout,
    input  logic          i_timeout_clr
);

    // Counter must hold TIMEOUT-1; keep at least one bit when the watchdog is off.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_FIRE = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    state_e        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    logic [1:0]    pick;
    logic          fire;
    logic          busy;
    logic          sel;

    // Master signals gathered into arrays so both ports share one routing template.
    logic [1:0]    m_cs;
    logic [1:0]    m_we;
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wdat [2];
    logic [1:0]    m_ack;
    logic [DW-1:0] m_rdat [2];

    assign m_cs      = {i_m1_cs, i_m0_cs};
    assign m_we      = {i_m1_we, i_m0_we};
    assign m_addr[0] = i_m0_addr;
    assign m_addr[1] = i_m1_addr;
    assign m_wdat[0] = i_m0_dat;
    assign m_wdat[1] = i_m1_dat;

    dcpu_rr_pick u_pick (
        .req  (m_cs),
        .last (last_q),
        .gnt  (pick)
    );

    // Watchdog fires on the last allowed BUSY cycle only if the slave stays silent.
    always_comb begin
        fire = (TIMEOUT > 0) && (state_q == ST_BUSY) && (cnt_q == CNT_FIRE) && !i_s_ack;
    end

    // Next-state: arbitrate in IDLE, finish on ack or watchdog in BUSY.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;

        // Clear first so a same-cycle fire overrides it.
        if (i_timeout_clr) timeout_d = 1'b0;
        if (fire)          timeout_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (pick != GNT_NONE) begin
                    state_d = ST_BUSY;
                    grant_d = pick;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if (i_s_ack || fire) begin
                    // Returning to IDLE guarantees one turnaround cycle.
                    state_d = ST_IDLE;
                    grant_d = GNT_NONE;
                    last_d  = grant_q[M1];
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
            end
        endcase
    end

    // State register with synchronous active-low reset; M1 counts as last owner.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= GNT_NONE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Outputs are gated by reset so the slave is released in the reset cycle itself.
    assign busy     = (state_q == ST_BUSY) && i_reset_n;
    assign sel      = grant_q[M1];
    assign o_s_cs   = busy;
    assign o_s_we   = busy & m_we[sel];
    assign o_s_addr = busy ? m_addr[sel] : '0;
    assign o_s_dat  = busy ? m_wdat[sel] : '0;

    // Ack and read data go only to the granted master, and only while it still requests.
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        assign m_ack[gi]  = busy & grant_q[gi] & m_cs[gi] & (i_s_ack | fire);
        assign m_rdat[gi] = (busy & grant_q[gi] & m_cs[gi] & i_s_ack) ? i_s_dat : '0;
    end

    assign o_m0_ack  = m_ack[0];
    assign o_m0_dat  = m_rdat[0];
    assign o_m1_ack  = m_ack[1];
    assign o_m1_dat  = m_rdat[1];
    assign o_grant   = i_reset_n ? grant_q : GNT_NONE;
    assign o_timeout = timeout_q & i_reset_n;

endmodule

// File: tb/tb_dcpu_bus_arbiter.sv
// Bench for dcpu_bus_arbiter: cycle vectors through a scoreboard queue, then a
// hand-written contention sequence checking strict alternation after reset.
module tb_dcpu_bus_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_m0_cs, i_m0_we, i_m1_cs, i_m1_we;
    logic [15:0] i_m0_addr, i_m0_dat, i_m1_addr, i_m1_dat;
    logic [15:0] o_m0_dat, o_m1_dat;
    logic        o_m0_ack, o_m1_ack;
    logic        o_s_cs, o_s_we;
    logic [15:0] o_s_addr, o_s_dat, i_s_dat;
    logic        i_s_ack;
    logic [1:0]  o_grant;
    logic        o_timeout, i_timeout_clr;

    always #5 i_clk = ~i_clk;

    dcpu_bus_arbiter #(.AW(16), .DW(16), .TIMEOUT(4)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_m0_cs(i_m0_cs), .i_m0_we(i_m0_we), .i_m0_addr(i_m0_addr), .i_m0_dat(i_m0_dat),
        .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack),
        .i_m1_cs(i_m1_cs), .i_m1_we(i_m1_we), .i_m1_addr(i_m1_addr), .i_m1_dat(i_m1_dat),
        .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack),
        .o_s_cs(o_s_cs), .o_s_we(o_s_we), .o_s_addr(o_s_addr), .o_s_dat(o_s_dat),
        .i_s_dat(i_s_dat), .i_s_ack(i_s_ack),
        .o_grant(o_grant), .o_timeout(o_timeout), .i_timeout_clr(i_timeout_clr)
    );

    typedef struct packed {
        logic        rst_n;
        logic        m0_cs, m0_we;
        logic [15:0] m0_addr, m0_dat;
        logic        m1_cs, m1_we;
        logic [15:0] m1_addr, m1_dat;
        logic        s_ack;
        logic [15:0] s_dat;
        logic        clr;
    } in_t;

    typedef struct packed {
        logic        s_cs, s_we;
        logic [15:0] s_addr, s_dat;
        logic        m0_ack;
        logic [15:0] m0_dat;
        logic        m1_ack;
        logic [15:0] m1_dat;
        logic [1:0]  grant;
        logic        timeout;
    } out_t;

    typedef struct { in_t i; out_t o; } vec_t;
    typedef struct { int idx; out_t o; } sb_t;

    vec_t tbl [$];
    sb_t  sb  [$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic in_t mk_in(logic rst, logic c0, logic w0, logic [15:0] a0, logic [15:0] d0,
                                  logic c1, logic w1, logic [15:0] a1, logic [15:0] d1,
                                  logic sa, logic [15:0] sd, logic clr);
        return '{rst, c0, w0, a0, d0, c1, w1, a1, d1, sa, sd, clr};
    endfunction

    function automatic out_t mk_out(logic scs, logic swe, logic [15:0] sa, logic [15:0] sd,
                                    logic k0, logic [15:0] r0, logic k1, logic [15:0] r1,
                                    logic [1:0] g, logic to);
        return '{scs, swe, sa, sd, k0, r0, k1, r1, g, to};
    endfunction

    task automatic drive(input in_t x);
        i_reset_n     = x.rst_n;
        i_m0_cs       = x.m0_cs;   i_m0_we  = x.m0_we;
        i_m0_addr     = x.m0_addr; i_m0_dat = x.m0_dat;
        i_m1_cs       = x.m1_cs;   i_m1_we  = x.m1_we;
        i_m1_addr     = x.m1_addr; i_m1_dat = x.m1_dat;
        i_s_ack       = x.s_ack;   i_s_dat  = x.s_dat;
        i_timeout_clr = x.clr;
    endtask

    function automatic out_t sample();
        return {o_s_cs, o_s_we, o_s_addr, o_s_dat, o_m0_ack, o_m0_dat,
                o_m1_ack, o_m1_dat, o_grant, o_timeout};
    endfunction

    task automatic check(input string name, input out_t got, input out_t exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got {scs,swe,addr,sdat,ack0,dat0,ack1,dat1,gnt,to}=%h required %h",
                     name, got, exp);
        end else begin
            $display("ok   %s: outputs=%h", name, got);
        end
    endtask

    // Scoreboard consumer: compare the DUT against the oldest pending expectation.
    always @(negedge i_clk) begin
        if (sb.size() > 0) begin
            sb_t e;
            e = sb.pop_front();
            check($sformatf("vec%0d", e.idx), sample(), e.o);
        end
    end

    // Global time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL time_limit: got no completion required completion");
        $fatal(1, "time limit");
    end

    initial begin
        in_t  idle, m0_rd10, m1_wr, m0_rd20, m1_rd40, both, m0_rd60, m0_drop;
        out_t z, tmo;
        logic [1:0] gseq [8];

        drive(mk_in(0, 0,0,0,0, 0,0,0,0, 0,0,0));

        idle    = mk_in(1, 0,0,16'h0000,0, 0,0,16'h0000,0, 0,16'h0000,0);
        m0_rd10 = mk_in(1, 1,0,16'h0010,0, 0,0,0,0, 0,0,0);
        m1_wr   = mk_in(1, 0,0,0,0, 1,1,16'h8000,16'hBEEF, 0,0,0);
        m0_rd20 = mk_in(1, 1,0,16'h0020,0, 0,0,0,0, 0,16'h7777,0);
        m1_rd40 = mk_in(1, 0,0,0,0, 1,0,16'h0040,0, 0,0,0);
        both    = mk_in(1, 1,0,16'h0050,0, 1,0,16'h0040,0, 0,0,0);
        m0_rd60 = mk_in(1, 1,0,16'h0060,0, 0,0,0,0, 0,0,0);
        m0_drop = mk_in(1, 0,0,16'h0060,0, 0,0,0,0, 0,0,0);
        z       = mk_out(0,0,0,0, 0,0, 0,0, 2'b00, 0);
        tmo     = mk_out(0,0,0,0, 0,0, 0,0, 2'b00, 1);

        // Reset, then a single M0 read acked two cycles after its request.
        tbl.push_back('{mk_in(0, 0,0,0,0, 0,0,0,0, 0,0,0), z});
        tbl.push_back('{mk_in(0, 0,0,0,0, 0,0,0,0, 0,0,0), z});
        tbl.push_back('{m0_rd10, z});
        tbl.push_back('{m0_rd10, mk_out(1,0,16'h0010,0, 0,0, 0,0, 2'b01, 0)});
        tbl.push_back('{mk_in(1, 1,0,16'h0010,0, 0,0,0,0, 1,16'h1234,0),
                        mk_out(1,0,16'h0010,0, 1,16'h1234, 0,0, 2'b01, 0)});
        tbl.push_back('{idle, z});
        // M1 write while M0 is quiet.
        tbl.push_back('{m1_wr, z});
        tbl.push_back('{m1_wr, mk_out(1,1,16'h8000,16'hBEEF, 0,0, 0,0, 2'b10, 0)});
        tbl.push_back('{mk_in(1, 0,0,0,0, 1,1,16'h8000,16'hBEEF, 1,16'h5555,0),
                        mk_out(1,1,16'h8000,16'hBEEF, 0,0, 1,16'h5555, 2'b10, 0)});
        tbl.push_back('{idle, z});
        // Spurious slave ack while idle.
        tbl.push_back('{mk_in(1, 0,0,0,0, 0,0,0,0, 1,16'hAAAA,0), z});
        tbl.push_back('{idle, z});
        // Slave never acks: forced completion on the 4th BUSY cycle, sticky flag, clear.
        tbl.push_back('{m0_rd20, z});
        for (int k = 0; k < 3; k++)
            tbl.push_back('{m0_rd20, mk_out(1,0,16'h0020,0, 0,0, 0,0, 2'b01, 0)});
        tbl.push_back('{m0_rd20, mk_out(1,0,16'h0020,0, 1,0, 0,0, 2'b01, 0)});
        tbl.push_back('{mk_in(1, 0,0,0,0, 0,0,0,0, 0,16'h7777,0), tmo});
        tbl.push_back('{idle, tmo});
        tbl.push_back('{mk_in(1, 0,0,0,0, 0,0,0,0, 0,0,1), tmo});
        tbl.push_back('{idle, z});
        // Reset during an M1 transaction, then a tie goes to M0.
        tbl.push_back('{m1_rd40, z});
        tbl.push_back('{m1_rd40, mk_out(1,0,16'h0040,0, 0,0, 0,0, 2'b10, 0)});
        tbl.push_back('{mk_in(0, 0,0,0,0, 1,0,16'h0040,0, 0,0,0), z});
        tbl.push_back('{both, z});
        tbl.push_back('{both, mk_out(1,0,16'h0050,0, 0,0, 0,0, 2'b01, 0)});
        tbl.push_back('{mk_in(1, 1,0,16'h0050,0, 1,0,16'h0040,0, 1,16'h1111,0),
                        mk_out(1,0,16'h0050,0, 1,16'h1111, 0,0, 2'b01, 0)});
        tbl.push_back('{m1_rd40, z});
        tbl.push_back('{mk_in(1, 0,0,0,0, 1,0,16'h0040,0, 1,16'h2222,0),
                        mk_out(1,0,16'h0040,0, 0,0, 1,16'h2222, 2'b10, 0)});
        tbl.push_back('{idle, z});
        // Granted master drops cs before ack: bus stays owned, ack discarded.
        tbl.push_back('{m0_rd60, z});
        tbl.push_back('{m0_drop, mk_out(1,0,16'h0060,0, 0,0, 0,0, 2'b01, 0)});
        tbl.push_back('{mk_in(1, 0,0,16'h0060,0, 0,0,0,0, 1,16'h3333,0),
                        mk_out(1,0,16'h0060,0, 0,0, 0,0, 2'b01, 0)});
        tbl.push_back('{idle, z});

        for (int k = 0; k < tbl.size(); k++) begin
            @(posedge i_clk);
            #1;
            drive(tbl[k].i);
            sb.push_back('{k, tbl[k].o});
        end

        // Contention after reset: both masters held, slave always acking.
        gseq = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        @(posedge i_clk);
        #1;
        drive(mk_in(0, 1,0,16'h0100,0, 1,0,16'h0200,0, 1,16'h0000,0));
        for (int k = 0; k < 8; k++) begin
            logic [15:0] sd;
            logic [15:0] ea;
            out_t        e;
            sd = 16'hC000 + 16'(k);
            @(posedge i_clk);
            #1;
            drive(mk_in(1, 1,0,16'h0100,0, 1,0,16'h0200,0, 1,sd,0));
            ea = (gseq[k] == 2'b01) ? 16'h0100 : (gseq[k] == 2'b10) ? 16'h0200 : 16'h0000;
            e = mk_out(gseq[k] != 2'b00, 0, ea, 0,
                       gseq[k] == 2'b01, (gseq[k] == 2'b01) ? sd : 16'h0000,
                       gseq[k] == 2'b10, (gseq[k] == 2'b10) ? sd : 16'h0000,
                       gseq[k], 0);
            @(negedge i_clk);
            check($sformatf("alt%0d", k), sample(), e);
        end

        @(posedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
